// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default widths and the request payload struct.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 64;
    localparam int unsigned ALU_CTRL_W = 5;
    localparam int unsigned ALU_TAG_W  = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD       = 5'b00000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB       = 5'b00001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND       = 5'b00010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR        = 5'b00011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR       = 5'b00100;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADDW      = 5'b01000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUBW      = 5'b01001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH1ADD    = 5'b10000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH2ADD    = 5'b10001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH3ADD    = 5'b10010;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD_UW    = 5'b10011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH1ADD_UW = 5'b10100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH2ADD_UW = 5'b10101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SH3ADD_UW = 5'b10110;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] src_a;
        logic [ALU_DATA_W-1:0] src_b;
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the winner of the next tie and
// only moves when a grant is actually taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // After granting requester i the pointer favours the other one.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && (gnt != 2'b00)) begin
            rr_ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between the integer issue path (0) and the
// Zba address-generation path (1) through an issue register and a result register.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned CTRL_W = ALU_CTRL_W,
    parameter int unsigned TAG_W  = ALU_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ReqValid,
    output logic [1:0]        ReqReady,
    input  logic [DATA_W-1:0] ReqSrcA0,
    input  logic [DATA_W-1:0] ReqSrcA1,
    input  logic [DATA_W-1:0] ReqSrcB0,
    input  logic [DATA_W-1:0] ReqSrcB1,
    input  logic [CTRL_W-1:0] ReqCtrl0,
    input  logic [CTRL_W-1:0] ReqCtrl1,
    input  logic [TAG_W-1:0]  ReqTag0,
    input  logic [TAG_W-1:0]  ReqTag1,
    output logic [1:0]        RspValid,
    input  logic [1:0]        RspReady,
    output logic [DATA_W-1:0] RspResult,
    output logic              RspZero,
    output logic [TAG_W-1:0]  RspTag,
    output logic [DATA_W-1:0] AluSrcA,
    output logic [DATA_W-1:0] AluSrcB,
    output logic [CTRL_W-1:0] AluControl,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,
    input  logic              Flush
);

    logic [1:0] gnt;
    logic [1:0] accept;
    logic       stall;
    logic       advance;
    alu_req_t   req_sel;

    alu_req_t          iss_req_q, iss_req_d;
    logic              iss_valid_q, iss_valid_d;
    logic              iss_owner_q, iss_owner_d;
    logic              res_valid_q, res_valid_d;
    logic              res_owner_q, res_owner_d;
    logic [DATA_W-1:0] res_result_q, res_result_d;
    logic              res_zero_q, res_zero_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    // Only the result register can back up; the issue stage moves whenever it drains.
    assign stall   = res_valid_q & ~RspReady[res_owner_q];
    assign advance = ~stall & ~Flush;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset   (reset),
        .req     (ReqValid),
        .advance (advance),
        .gnt     (gnt)
    );

    assign ReqReady = gnt & {2{advance & ~reset}};
    assign accept   = ReqValid & ReqReady;

    always_comb begin
        if (gnt[1]) begin
            req_sel.src_a = ReqSrcA1;
            req_sel.src_b = ReqSrcB1;
            req_sel.ctrl  = ReqCtrl1;
            req_sel.tag   = ReqTag1;
        end else begin
            req_sel.src_a = ReqSrcA0;
            req_sel.src_b = ReqSrcB0;
            req_sel.ctrl  = ReqCtrl0;
            req_sel.tag   = ReqTag0;
        end
    end

    always_comb begin
        iss_req_d    = iss_req_q;
        iss_valid_d  = iss_valid_q;
        iss_owner_d  = iss_owner_q;
        res_valid_d  = res_valid_q;
        res_owner_d  = res_owner_q;
        res_result_d = res_result_q;
        res_zero_d   = res_zero_q;
        res_tag_d    = res_tag_q;
        if (Flush) begin
            iss_valid_d = 1'b0;
            res_valid_d = 1'b0;
        end else if (advance) begin
            iss_valid_d = |accept;
            if (|accept) begin
                iss_req_d   = req_sel;
                iss_owner_d = accept[1];
            end
            res_valid_d  = iss_valid_q;
            res_owner_d  = iss_owner_q;
            res_result_d = AluResult;
            res_zero_d   = AluZero;
            res_tag_d    = iss_req_q.tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_req_q    <= '0;
            iss_valid_q  <= 1'b0;
            iss_owner_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_owner_q  <= 1'b0;
            res_result_q <= '0;
            res_zero_q   <= 1'b0;
            res_tag_q    <= '0;
        end else begin
            iss_req_q    <= iss_req_d;
            iss_valid_q  <= iss_valid_d;
            iss_owner_q  <= iss_owner_d;
            res_valid_q  <= res_valid_d;
            res_owner_q  <= res_owner_d;
            res_result_q <= res_result_d;
            res_zero_q   <= res_zero_d;
            res_tag_q    <= res_tag_d;
        end
    end

    // An idle issue slot presents ADD 0,0 so the ALU inputs never carry stale operands.
    assign AluSrcA    = iss_valid_q ? iss_req_q.src_a : '0;
    assign AluSrcB    = iss_valid_q ? iss_req_q.src_b : '0;
    assign AluControl = iss_valid_q ? iss_req_q.ctrl  : ALU_ADD;

    assign RspValid  = {res_valid_q & res_owner_q, res_valid_q & ~res_owner_q};
    assign RspResult = res_result_q;
    assign RspZero   = res_zero_q;
    assign RspTag    = res_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU closes the loop and a scoreboard
// tracks every accepted request through to its delivered result.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  ReqValid, ReqReady, RspValid, RspReady;
    logic [63:0] ReqSrcA0, ReqSrcA1, ReqSrcB0, ReqSrcB1;
    logic [4:0]  ReqCtrl0, ReqCtrl1, AluControl;
    logic [3:0]  ReqTag0, ReqTag1, RspTag;
    logic [63:0] RspResult, AluSrcA, AluSrcB, AluResult;
    logic        RspZero, AluZero, Flush;

    typedef struct {
        int          owner;
        logic [63:0] result;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_n;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] c);
        logic [63:0] auw;
        logic [31:0] w;
        auw = {32'h0, a[31:0]};
        case (c)
            ALU_ADD:       return a + b;
            ALU_SUB:       return a - b;
            ALU_AND:       return a & b;
            ALU_OR:        return a | b;
            ALU_XOR:       return a ^ b;
            ALU_ADDW:      begin w = a[31:0] + b[31:0]; return {{32{w[31]}}, w}; end
            ALU_SUBW:      begin w = a[31:0] - b[31:0]; return {{32{w[31]}}, w}; end
            ALU_SH1ADD:    return (a << 1) + b;
            ALU_SH2ADD:    return (a << 2) + b;
            ALU_SH3ADD:    return (a << 3) + b;
            ALU_ADD_UW:    return auw + b;
            ALU_SH1ADD_UW: return (auw << 1) + b;
            ALU_SH2ADD_UW: return (auw << 2) + b;
            ALU_SH3ADD_UW: return (auw << 3) + b;
            default:       return 64'h0;
        endcase
    endfunction

    assign AluResult = alu_ref(AluSrcA, AluSrcB, AluControl);
    assign AluZero   = (AluResult == 64'h0);

    alu_share_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqSrcA0   (ReqSrcA0),
        .ReqSrcA1   (ReqSrcA1),
        .ReqSrcB0   (ReqSrcB0),
        .ReqSrcB1   (ReqSrcB1),
        .ReqCtrl0   (ReqCtrl0),
        .ReqCtrl1   (ReqCtrl1),
        .ReqTag0    (ReqTag0),
        .ReqTag1    (ReqTag1),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspResult  (RspResult),
        .RspZero    (RspZero),
        .RspTag     (RspTag),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .AluControl (AluControl),
        .AluResult  (AluResult),
        .AluZero    (AluZero),
        .Flush      (Flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    // Scoreboard: handshakes sampled mid-cycle, they complete at the following edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (RspValid[i] && RspReady[i]) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_spurious: owner %0d got %h expected no result",
                                 i, RspResult);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.owner != i || RspResult !== mon_e.result ||
                            RspZero !== mon_e.zero || RspTag !== mon_e.tag) begin
                            miscompares++;
                            $display("FAIL sb_result: got own %0d res %h z %b tag %h, %s %0d %h %b %h",
                                     i, RspResult, RspZero, RspTag, "expected",
                                     mon_e.owner, mon_e.result, mon_e.zero, mon_e.tag);
                        end
                    end
                end
            end
            if (Flush) begin
                sb.delete();
            end else if (ReqValid[0] && ReqReady[0]) begin
                mon_n.owner  = 0;
                mon_n.result = alu_ref(ReqSrcA0, ReqSrcB0, ReqCtrl0);
                mon_n.zero   = (mon_n.result == 64'h0);
                mon_n.tag    = ReqTag0;
                sb.push_back(mon_n);
            end else if (ReqValid[1] && ReqReady[1]) begin
                mon_n.owner  = 1;
                mon_n.result = alu_ref(ReqSrcA1, ReqSrcB1, ReqCtrl1);
                mon_n.zero   = (mon_n.result == 64'h0);
                mon_n.tag    = ReqTag1;
                sb.push_back(mon_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] c, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] t);
        if (i == 0) begin
            ReqCtrl0 = c; ReqSrcA0 = a; ReqSrcB0 = b; ReqTag0 = t;
        end else begin
            ReqCtrl1 = c; ReqSrcA1 = a; ReqSrcB1 = b; ReqTag1 = t;
        end
    endtask

    task automatic test_reset();
        ReqValid = 2'b11;
        set_req(0, ALU_SUB, 64'h11, 64'h22, 4'h1);
        set_req(1, ALU_XOR, 64'h33, 64'h44, 4'h2);
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if (ReqReady !== 2'b00 || RspValid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_hs: got ready %b rspv %b expected 00 00", ReqReady, RspValid);
        end
        vectors++;
        if (RspResult !== 64'h0 || RspZero !== 1'b0 || RspTag !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got %h %b %h expected 0 0 0", RspResult, RspZero, RspTag);
        end
        vectors++;
        if (AluSrcA !== 64'h0 || AluSrcB !== 64'h0 || AluControl !== 5'h0) begin
            miscompares++;
            $display("FAIL reset_alu: got %h %h %h expected 0 0 0", AluSrcA, AluSrcB, AluControl);
        end
        ReqValid = 2'b00;
        reset    = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        RspReady = 2'b11;
        set_req(0, ALU_ADD, 64'd5, 64'd7, 4'h3);
        ReqValid = 2'b01;
        #1;
        vectors++;
        if (ReqReady !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 01", ReqReady);
        end
        tick();
        ReqValid = 2'b00;
        #1;
        vectors++;
        if (AluControl !== ALU_ADD || AluSrcA !== 64'd5 || AluSrcB !== 64'd7) begin
            miscompares++;
            $display("FAIL single_alu: got %h %h %h expected 0 5 7", AluControl, AluSrcA, AluSrcB);
        end
        tick();
        vectors++;
        if (RspValid !== 2'b01 || RspResult !== 64'd12 || RspZero !== 1'b0 || RspTag !== 4'h3)
        begin
            miscompares++;
            $display("FAIL single_rsp: got %b %h %b %h expected 01 c 0 3",
                     RspValid, RspResult, RspZero, RspTag);
        end
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [1:0]  g;
        logic [63:0] r;
        // A lone r1 op leaves the pointer favouring r0 for the tie that follows.
        set_req(1, ALU_ADD_UW, 64'hFFFF_FFFF_0000_0010, 64'd1, 4'h4);
        ReqValid = 2'b10;
        tick();
        set_req(0, ALU_SUB, 64'd9, 64'd9, 4'h1);
        set_req(1, ALU_SH2ADD, 64'd3, 64'h1000, 4'h2);
        ReqValid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            vectors++;
            if (ReqReady !== g) begin
                miscompares++;
                $display("FAIL contend_grant%0d: got %b expected %b", k, ReqReady, g);
            end
            if (k >= 2) begin
                r = (k % 2 == 0) ? 64'h0 : 64'h100C;
                vectors++;
                if (RspValid !== g || RspResult !== r || RspZero !== (k % 2 == 0)) begin
                    miscompares++;
                    $display("FAIL contend_rsp%0d: got %b %h %b expected %b %h", k,
                             RspValid, RspResult, RspZero, g, r);
                end
            end
            tick();
        end
        ReqValid = 2'b00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        RspReady = 2'b01;
        set_req(1, ALU_XOR, 64'hF0F0, 64'h0FF0, 4'h5);
        ReqValid = 2'b10;
        tick();
        set_req(0, ALU_OR, 64'h1234_0000, 64'h5678, 4'h6);
        ReqValid = 2'b01;
        tick();
        set_req(0, ALU_AND, 64'hFF, 64'h0F, 4'h7);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (ReqReady !== 2'b00 || RspValid !== 2'b10) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got ready %b rspv %b expected 00 10",
                         k, ReqReady, RspValid);
            end
            vectors++;
            if (RspResult !== 64'hFF00 || RspTag !== 4'h5 || AluSrcA !== 64'h1234_0000 ||
                AluControl !== ALU_OR) begin
                miscompares++;
                $display("FAIL bp_stable%0d: got %h %h %h %h expected ff00 5 12340000 3",
                         k, RspResult, RspTag, AluSrcA, AluControl);
            end
            tick();
        end
        RspReady = 2'b11;
        #1;
        vectors++;
        if (ReqReady !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 01", ReqReady);
        end
        tick();
        ReqValid = 2'b00;
        #1;
        vectors++;
        if (RspValid !== 2'b01 || RspResult !== 64'h1234_5678 || RspTag !== 4'h6) begin
            miscompares++;
            $display("FAIL bp_next: got %b %h %h expected 01 12345678 6",
                     RspValid, RspResult, RspTag);
        end
        tick();
        #1;
        vectors++;
        if (RspValid !== 2'b01 || RspResult !== 64'h0F || RspTag !== 4'h7) begin
            miscompares++;
            $display("FAIL bp_last: got %b %h %h expected 01 f 7", RspValid, RspResult, RspTag);
        end
        tick();
        tick();
    endtask

    task automatic test_word_ops();
        logic [4:0]  c[3];
        logic [63:0] a[3];
        logic [63:0] b[3];
        logic [63:0] r[3];
        int          n;
        c[0] = ALU_ADDW;      a[0] = 64'h7FFF_FFFF;            b[0] = 64'd1;
        r[0] = 64'hFFFF_FFFF_8000_0000;
        c[1] = 5'b01111;      a[1] = 64'd5;                    b[1] = 64'd6;
        r[1] = 64'h0;
        c[2] = ALU_SH3ADD_UW; a[2] = 64'hFFFF_FFFF_0000_0002;  b[2] = 64'd4;
        r[2] = 64'h14;
        for (int k = 0; k < 3; k++) begin
            set_req(k % 2, c[k], a[k], b[k], 4'(k + 8));
            ReqValid = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            ReqValid = 2'b00;
            n = 0;
            while (RspValid == 2'b00 && n < 10) begin
                tick();
                n++;
            end
            vectors++;
            if (RspResult !== r[k] || RspTag !== 4'(k + 8) || RspZero !== (r[k] == 64'h0)) begin
                miscompares++;
                $display("FAIL word_op%0d: got %h tag %h expected %h tag %h",
                         k, RspResult, RspTag, r[k], 4'(k + 8));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_flush();
        int n;
        RspReady = 2'b00;
        set_req(0, ALU_ADD, 64'h10, 64'h20, 4'h8);
        ReqValid = 2'b01;
        tick();
        set_req(1, ALU_SUB, 64'd100, 64'd1, 4'h9);
        ReqValid = 2'b10;
        tick();
        vectors++;
        if (RspValid !== 2'b01 || AluSrcA !== 64'd100) begin
            miscompares++;
            $display("FAIL flush_full: got %b %h expected 01 64", RspValid, AluSrcA);
        end
        Flush    = 1'b1;
        ReqValid = 2'b11;
        #1;
        vectors++;
        if (ReqReady !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_ready: got %b expected 00", ReqReady);
        end
        tick();
        Flush    = 1'b0;
        ReqValid = 2'b00;
        RspReady = 2'b11;
        #1;
        vectors++;
        if (RspValid !== 2'b00 || AluSrcA !== 64'h0 || AluControl !== 5'h0) begin
            miscompares++;
            $display("FAIL flush_empty: got %b %h %h expected 00 0 0",
                     RspValid, AluSrcA, AluControl);
        end
        set_req(0, ALU_ADD, 64'd1, 64'd2, 4'hA);
        ReqValid = 2'b01;
        tick();
        ReqValid = 2'b00;
        n = 0;
        while (RspValid == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (RspValid !== 2'b01 || RspResult !== 64'd3 || RspTag !== 4'hA) begin
            miscompares++;
            $display("FAIL flush_after: got %b %h %h expected 01 3 a", RspValid, RspResult, RspTag);
        end
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        set_req(0, ALU_ADD, 64'd1, 64'd1, 4'h1);
        set_req(1, ALU_ADD, 64'd2, 64'd2, 4'h2);
        RspReady = 2'b11;
        ReqValid = 2'b11;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (ReqReady !== 2'b00 || RspValid !== 2'b00 || RspResult !== 64'h0 ||
            RspZero !== 1'b0 || RspTag !== 4'h0) begin
            miscompares++;
            $display("FAIL areset_rsp: got %b %b %h %b %h expected all 0",
                     ReqReady, RspValid, RspResult, RspZero, RspTag);
        end
        vectors++;
        if (AluSrcA !== 64'h0 || AluSrcB !== 64'h0 || AluControl !== 5'h0) begin
            miscompares++;
            $display("FAIL areset_alu: got %h %h %h expected 0 0 0", AluSrcA, AluSrcB, AluControl);
        end
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (ReqReady !== 2'b01) begin
            miscompares++;
            $display("FAIL areset_first: got %b expected 01", ReqReady);
        end
        tick();
        ReqValid = 2'b00;
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        reset    = 1'b1;
        Flush    = 1'b0;
        RspReady = 2'b00;
        ReqValid = 2'b00;
        set_req(0, ALU_ADD, 64'h0, 64'h0, 4'h0);
        set_req(1, ALU_ADD, 64'h0, 64'h0, 4'h0);

        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_word_ops();
        test_flush();
        test_async_reset();

        for (int k = 0; k < 3; k++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d undelivered results expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: requester 0 is the integer issue path, requester 1 is the Zba address-generation path.
- Round-robin arbitration, valid/ready handshakes on both sides.
- One issue register feeds the ALU operands. One result register returns the result to the owning requester.
- The ALU stays combinational and lives outside this block. This block only sequences it.

Parameters:
- DATA_W, 64, operand/result width.
- CTRL_W, 5, ALU operation-code width.
- TAG_W, 4, opaque requester tag, returned unchanged with the result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  2  per-requester request valid.
- ReqReady  out  2  per-requester request accepted this cycle.
- ReqSrcA0, ReqSrcA1  in  DATA_W  operand A per requester.
- ReqSrcB0, ReqSrcB1  in  DATA_W  operand B per requester.
- ReqCtrl0, ReqCtrl1  in  CTRL_W  ALU opcode per requester.
- ReqTag0, ReqTag1  in  TAG_W  request tag.
- RspValid  out  2  result valid toward its owner only.
- RspReady  in  2  owner accepts result.
- RspResult  out  DATA_W  shared result bus.
- RspZero  out  1  registered ALU Zero flag.
- RspTag  out  TAG_W  tag of the returned result.
- AluSrcA, AluSrcB  out  DATA_W  to ALU.
- AluControl  out  CTRL_W  to ALU.
- AluResult  in  DATA_W  from ALU.
- AluZero  in  1  from ALU.
- Flush  in  1  synchronous kill of all in-flight work.

Behaviour:
- Reset (async assert) clears the following:
  - IssValid=0, ResValid=0, RrPtr=0.
  - RspValid=0, RspResult=0, RspZero=0, RspTag=0.
  - AluSrcA=0, AluSrcB=0, AluControl=0.
  - ReqReady=0 while reset is high.
- Stall = ResValid & ~RspReady[ResOwner]. Advance = ~Stall & ~Flush.
- Grant (combinational):
  - If only one ReqValid is high, that requester is granted.
  - If both are high, the requester indicated by RrPtr is granted.
  - If none are high, there is no grant.
- ReqReady[i] = Grant[i] & Advance. At most one bit is high.
- Accept (ReqValid & ReqReady):
  - Loads the issue register with operands, opcode, tag and Owner=i.
  - Sets IssValid.
  - Sets RrPtr = ~i. RrPtr is unchanged when nothing is accepted.
- Advance with no accept clears IssValid.
- AluSrcA, AluSrcB and AluControl are driven from the issue register. They are forced to 0 (ADD, zero operands) when IssValid=0.
- Result register:
  - On Advance, loads AluResult, AluZero, the tag and the owner, and sets ResValid=IssValid.
  - On Stall, it holds.
- RspValid[i] = ResValid & (ResOwner==i). RspResult, RspZero and RspTag hold stable while RspValid is high and not accepted.
- Latency:
  - Request accepted at edge N.
  - ALU is driven during cycle N+1.
  - RspValid is high from edge N+1 onward (result registered at N+1, visible in cycle N+2 after the edge).
  - Throughput is one op per cycle with no backpressure.
- Backpressure:
  - While stalled, the issue register and ALU inputs hold and ReqReady=00.
  - There is no bypass and no skid beyond the two registers.
- Flush:
  - Takes effect at the next edge: IssValid=0, ResValid=0, RrPtr unchanged.
  - ReqReady=00 in the Flush cycle.
  - A result handshake (RspValid & RspReady) coinciding with Flush still counts as delivered.
- Simultaneous events:
  - Response acceptance and new request acceptance in the same cycle are both legal, giving full throughput.
  - Flush beats both.
  - Reset beats everything.
- Requester rule: payload must stay stable while ReqValid is high and not accepted. The block does not check this.
- Fairness: with both requesters continuously valid, grants alternate strictly 0,1,0,1. No requester waits more than one accept.
- Opcode is passed through unchecked. Undefined opcodes return whatever the ALU produces (0).

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, ADDW 01000, SUBW 01001, SH1ADD..SH3ADD 10000-10010, ADD.UW 10011, SH1ADD.UW..SH3ADD.UW 10100-10110.
  - Width localparams.
  - Packed struct alu_req_t {SrcA, SrcB, Ctrl, Tag}.
- One sub-module: rr_arbiter2, holding the combinational grant logic plus the RrPtr flop, with inputs req[1:0] and advance and output gnt[1:0].

Test Plan:
- Single op: requester 0 sends ADD 5+7, tag 3, with RspReady=11 → ReqReady[0] high in the request cycle; ALU sees ADD, 5, 7 the next cycle; RspValid=01, RspResult=12, RspZero=0, RspTag=3 the cycle after.
- Contention: both valid for 4 cycles, r0 SUB 9-9, r1 SH2ADD A=3 B=0x1000, RspReady=11 → grants 0,1,0,1; responses 0 (Zero=1) and 0x100C, each to the correct owner.
- Backpressure: r1 result pending with RspReady[1]=0 for 3 cycles while r0 stays valid → ReqReady=00 and result bits stable during the hold; on release, ordered delivery with no loss or duplication.
- Word op: ADDW with A=0x7FFFFFFF, B=1 → RspResult=0xFFFFFFFF80000000.
- Flush with both registers full → next cycle RspValid=00, IssValid=0; the next request completes normally with the correct tag.
- Async reset mid-stream: reset asserted between edges → all outputs 0 immediately; after release the first grant goes to requester 0 when both are valid.
